// File: rtl/logic_unit_arbiter_if.sv
// Request/grant and result bus shared between the requesters and the logic-unit arbiter.
// Requester slice i occupies op[2i+:2], a[WIDTH*i+:WIDTH], b[WIDTH*i+:WIDTH].
interface logic_unit_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] a;
    logic [WIDTH*N_REQ-1:0] b;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   res_valid;
    logic [IDW-1:0]         res_id;
    logic [WIDTH-1:0]       res_data;

    modport master (
        output req, op, a, b,
        input  gnt, busy, res_valid, res_id, res_data
    );

    modport slave (
        input  req, op, a, b,
        output gnt, busy, res_valid, res_id, res_data
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered NOT/AND/OR/XOR unit; optional grant counter under LU_GRANT_COUNT_EN.
// Latency: gnt one cycle after req is seen idle, res_valid two cycles after gnt; one transaction per 3 cycles.
// Backpressure: req is held until gnt; requests are only sampled in IDLE, results are never stalled.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus
`ifdef LU_GRANT_COUNT_EN
    ,
    output logic [15:0]          grant_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } txn_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    txn_t             txn_q, txn_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             res_valid_q, res_valid_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    txn_t             req_txn [N_REQ];
    logic             sel_vld;
    logic [IDW-1:0]   sel_idx;
    txn_t             sel_txn;

    function automatic logic [WIDTH-1:0] lu_eval(input logic [1:0]       fop,
                                                 input logic [WIDTH-1:0] fa,
                                                 input logic [WIDTH-1:0] fb);
        logic [WIDTH-1:0] r;
        unique case (fop)
            2'b00:   r = ~fa;
            2'b01:   r = fa & fb;
            2'b10:   r = fa | fb;
            default: r = fa ^ fb;
        endcase
        return r;
    endfunction

    // Round-robin search: first pass covers indices above the last winner,
    // second pass wraps around to the indices at or below it.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        sel_txn = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_txn[i].op = bus.op[2*i +: 2];
            req_txn[i].a  = bus.a[WIDTH*i +: WIDTH];
            req_txn[i].b  = bus.b[WIDTH*i +: WIDTH];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!sel_vld && bus.req[i] && (i > int'(last_q))) begin
                sel_vld = 1'b1;
                sel_idx = IDW'(i);
                sel_txn = req_txn[i];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!sel_vld && bus.req[i] && (i <= int'(last_q))) begin
                sel_vld = 1'b1;
                sel_idx = IDW'(i);
                sel_txn = req_txn[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        txn_d       = txn_q;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    txn_d   = sel_txn;
                    last_d  = sel_idx;
                    id_d    = sel_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d = lu_eval(txn_q.op, txn_q.a, txn_q.b);
                res_id_d   = id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                res_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer resets to the top index so requester 0 wins the first round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= IDW'(N_REQ-1);
            id_q        <= '0;
            txn_q       <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            txn_q       <= txn_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;

`ifdef LU_GRANT_COUNT_EN
    logic [15:0] grant_count_q, grant_count_d;

    // Counts alongside the grant being registered; saturates instead of wrapping.
    always_comb begin
        grant_count_d = grant_count_q;
        if ((state_q == ST_IDLE) && sel_vld && (grant_count_q != 16'hFFFF)) begin
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed plus randomized bench for logic_unit_arbiter with a transaction-level reference model.
module tb_logic_unit_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.N_REQ(N), .WIDTH(W), .IDW(IW)) bus ();
`ifdef LU_GRANT_COUNT_EN
    logic [15:0] grant_count;
`endif

    logic_unit_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LU_GRANT_COUNT_EN
        ,
        .grant_count (grant_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: pointer, cycles until free, scheduled result events.
    int          m_last;
    int          m_free_cd;
    int          m_data_cd;
    int          m_valid_cd;
    logic [N-1:0] e_gnt;
    logic         e_valid;
    logic [W-1:0] e_data, p_data;
    int           e_id, p_id;
    int           e_cnt;

    logic [W-1:0] dir_exp [4];
    logic [1:0]   dir_op  [4];

    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'b00:   return ~x;
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1; m_free_cd = 0; m_data_cd = 0; m_valid_cd = 0;
        e_gnt = '0; e_valid = 1'b0; e_data = '0; e_id = 0; p_data = '0; p_id = 0; e_cnt = 0;
    endtask

    // Predicts what the outputs show after the coming edge from the current inputs.
    task automatic model_edge();
        int sel;
        sel = -1;
        e_gnt   = '0;
        e_valid = 1'b0;
        if (m_data_cd > 0) begin
            m_data_cd--;
            if (m_data_cd == 0) begin e_data = p_data; e_id = p_id; end
        end
        if (m_valid_cd > 0) begin
            m_valid_cd--;
            if (m_valid_cd == 0) e_valid = 1'b1;
        end
        if (m_free_cd > 0) begin
            m_free_cd--;
        end else if (bus.req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (sel < 0 && bus.req[c]) sel = c;
            end
            e_gnt      = N'(1) << sel;
            m_last     = sel;
            p_id       = sel;
            p_data     = ref_op(bus.op[2*sel +: 2], bus.a[W*sel +: W], bus.b[W*sel +: W]);
            m_data_cd  = 1;
            m_valid_cd = 2;
            m_free_cd  = 2;
            if (e_cnt < 65535) e_cnt++;
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        chk("busy", 32'(bus.busy), 32'(m_free_cd > 0));
        chk("res_valid", 32'(bus.res_valid), 32'(e_valid));
        chk("res_id", 32'(bus.res_id), 32'(e_id));
        chk("res_data", 32'(bus.res_data), 32'(e_data));
`ifdef LU_GRANT_COUNT_EN
        chk("grant_count", 32'(grant_count), 32'(e_cnt));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.req[i]         = 1'b1;
        bus.op[2*i +: 2]   = o;
        bus.a[W*i +: W]    = x;
        bus.b[W*i +: W]    = y;
    endtask

    // Random requesters obeying the handshake: hold until granted, then drop or re-request.
    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (e_gnt[i]) begin
                bus.a[W*i +: W] = W'($urandom);
                bus.b[W*i +: W] = W'($urandom);
                bus.op[2*i +: 2] = 2'($urandom);
                bus.req[i] = ($urandom_range(0, 2) == 0);
            end else if (!bus.req[i]) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, 2'($urandom), W'($urandom), W'($urandom));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        dir_op[0] = 2'b01; dir_exp[0] = 8'h30;
        dir_op[1] = 2'b00; dir_exp[1] = 8'h0F;
        dir_op[2] = 2'b10; dir_exp[2] = 8'hFC;
        dir_op[3] = 2'b11; dir_exp[3] = 8'hCC;

        // Reset with every requester asking.
        bus.req = '1;
        for (int i = 0; i < N; i++) begin
            bus.op[2*i +: 2] = 2'($urandom);
            bus.a[W*i +: W]  = W'($urandom);
            bus.b[W*i +: W]  = W'($urandom);
        end
        model_reset();
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rst_res_id", 32'(bus.res_id), 32'h0);
        chk("rst_res_data", 32'(bus.res_data), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 1; s <= 13; s++) begin
            step();
            if (s % 3 == 1) chk("rr_seq", 32'(bus.gnt), 32'(1) << ((s / 3) % 4));
        end

        // Drain, then single requester 2 through all opcodes.
        bus.req = '0;
        repeat (3) step();
        for (int t = 0; t < 4; t++) begin
            set_req(2, dir_op[t], 8'hF0, 8'h3C);
            step();
            chk("single_gnt", 32'(bus.gnt), 32'b0100);
            bus.req = '0;
            step();
            step();
            chk("single_valid", 32'(bus.res_valid), 32'h1);
            chk("single_id", 32'(bus.res_id), 32'd2);
            chk("single_data", 32'(bus.res_data), 32'(dir_exp[t]));
        end

        // Operand change after grant must not leak into the result.
        set_req(1, 2'b11, 8'hAA, 8'hFF);
        step();
        chk("latch_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        bus.a[W*1 +: W] = 8'h55;
        step();
        step();
        chk("latch_data", 32'(bus.res_data), 32'h55);

        // Move pointer to 0, then contend 3 vs 0.
        set_req(0, 2'b01, 8'hFF, 8'h0F);
        step();
        bus.req = '0;
        repeat (2) step();
        set_req(0, 2'b10, 8'h01, 8'h02);
        set_req(3, 2'b00, 8'h0F, 8'h00);
        step();
        chk("rr_first3", 32'(bus.gnt), 32'b1000);
        bus.req[3] = 1'b0;
        repeat (2) step();
        step();
        chk("rr_then0", 32'(bus.gnt), 32'b0001);
        bus.req[0] = 1'b0;
        repeat (2) step();
        chk("rr_res0", 32'(bus.res_data), 32'h03);
        repeat (3) step();

        // Reset during EXEC discards the pending result and restores the pointer.
        set_req(2, 2'b11, 8'h12, 8'h34);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_res_data", 32'(bus.res_data), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = '1;
        step();
        chk("post_rst_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        repeat (3) step();
`ifdef LU_GRANT_COUNT_EN
        chk("gcount_after1", 32'(grant_count), 32'd1);
`endif

        // Randomized traffic against the model.
        for (int s = 0; s < 3000; s++) begin
            step();
            drive_random();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered bitwise logic unit (NOT/AND/OR/XOR, WIDTH bits) between N_REQ requesters.
- Each requester presents an operation and operands under a req/gnt handshake. The arbiter grants one requester and latches its operands.
- The result is delivered on a single result port, tagged with the requester index.
- Sits between the gate-level datapath blocks and any client that needs gate evaluation.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- IDW, $clog2(N_REQ), width of the requester index

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req  input  N_REQ  per-requester request; held high until gnt
- op  input  2*N_REQ  per-requester opcode, slice i = op[2i+1:2i]
- a  input  WIDTH*N_REQ  per-requester operand A, slice i
- b  input  WIDTH*N_REQ  per-requester operand B, slice i (ignored for NOT)
- gnt  output  N_REQ  one-hot grant pulse, one cycle
- busy  output  1  high while a transaction is in flight (state != IDLE)
- res_valid  output  1  one-cycle result strobe
- res_id  output  IDW  index of the requester owning res_data
- res_data  output  WIDTH  logic unit result

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - FSM=IDLE, gnt=0, busy=0, res_valid=0, res_id=0, res_data=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority after reset.
- Opcodes: 00 NOT a; 01 a AND b; 10 a OR b; 11 a XOR b. Bitwise, WIDTH bits, no carry or extension.
- FSM IDLE:
  - If req==0, stay.
  - Otherwise select the first set req bit searching last+1, last+2, ... with wrap modulo N_REQ.
  - Registered at the edge: gnt[sel]=1, latch op/a/b of sel, last<=sel, id<=sel. Go to EXEC.
- FSM EXEC:
  - gnt returns to 0.
  - Compute on the latched operands; res_data<=f(op,a,b), res_id<=id. Go to RESP.
- FSM RESP:
  - res_valid=1 for exactly this one cycle. Go to IDLE.
  - A new arbitration can start on the next cycle.
- Timing:
  - gnt is high in the cycle after req is first seen in IDLE.
  - res_valid is high 2 cycles after gnt.
  - Peak throughput is 1 transaction per 3 cycles.
- Handshake rules:
  - The requester must hold req and its operands stable until it sees gnt.
  - It drops req the cycle after gnt unless it issues a back-to-back request.
  - Operand changes after the grant edge have no effect.
- res_data and res_id hold their values after res_valid falls, until the next EXEC.
- busy = (state != IDLE).
- Simultaneous requests: exactly one grant per transaction. A requester that was just granted has lowest priority next round (no starvation: worst-case wait is N_REQ-1 transactions).
- req deasserted before grant: no grant to that requester, no error.
- req changes during EXEC/RESP: ignored; only sampled in IDLE.
- rst_n asserted mid-transaction:
  - Immediate return to the reset values above. Any pending result is discarded and no res_valid is issued.
  - The pointer returns to N_REQ-1.

Optional Feature:
- Macro LU_GRANT_COUNT_EN.
- When defined:
  - Adds output grant_count (16 bits).
  - It increments by 1 on every gnt pulse and saturates at 16'hFFFF without wrap.
  - Reset value is 0, cleared by rst_n.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with req=4'b1111 held: release rst_n -> first gnt=4'b0001 one cycle later; grants then cycle 0001, 0010, 0100, 1000, 0001 every 3 cycles.
- Single requester 2, op=01, a=8'hF0, b=8'h3C -> gnt=4'b0100; 2 cycles later res_valid=1, res_id=2, res_data=8'h30. Repeat with op=00 -> 8'h0F, op=10 -> 8'hFC, op=11 -> 8'hCC.
- Requester 1 changes a from 8'hAA to 8'h55 the cycle after its gnt, op=11, b=8'hFF -> res_data=8'h55 (latched 8'hAA used).
- req=4'b1001 with last=0 -> requester 3 is granted first, then 0; the granted requester drops req and is not granted again.
- rst_n pulsed low during EXEC -> gnt=0, busy=0, res_valid stays 0, res_data=0; the next grant honours the reset pointer (lowest index first).
- With LU_GRANT_COUNT_EN: 5 completed transactions -> grant_count=5; reset -> 0. Force the counter near saturation via a long run -> holds at 16'hFFFF.
